// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side handshake between the decode stage and the hazard/forward/flush controller.
// The master drives decode and jump information; the slave returns the stall, forward and flush decisions.
interface pipe_hazard_ctrl_if #(
   parameter int NSTAGE = 3,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16,
   parameter int SEL_W  = $clog2(NSTAGE + 1)
);
   logic              dec_valid;
   logic [REG_W-1:0]  dec_rs1_ind;
   logic              dec_rs1_use;
   logic [REG_W-1:0]  dec_rs2_ind;
   logic              dec_rs2_use;
   logic [REG_W-1:0]  dec_rd_ind;
   logic              dec_rd_we;
   logic              dec_is_load;
   logic              jmp_take;
   logic              stall;
   logic              issue;
   logic [SEL_W-1:0]  fwd_rs1_sel;
   logic [SEL_W-1:0]  fwd_rs2_sel;
   logic              flush_d;
   logic [NSTAGE-1:0] flush_vec;
   logic [SEL_W-1:0]  inflight_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output dec_valid, dec_rs1_ind, dec_rs1_use, dec_rs2_ind, dec_rs2_use,
             dec_rd_ind, dec_rd_we, dec_is_load, jmp_take,
      input  stall, issue, fwd_rs1_sel, fwd_rs2_sel, flush_d, flush_vec,
             inflight_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  dec_valid, dec_rs1_ind, dec_rs1_use, dec_rs2_ind, dec_rs2_use,
             dec_rd_ind, dec_rd_we, dec_is_load, jmp_take,
      output stall, issue, fwd_rs1_sel, fwd_rs2_sel, flush_d, flush_vec,
             inflight_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and jump-flush controller: tracks in-flight destination registers in a
// shadow pipeline and decides stall / bypass source / squash for the instruction in decode.
module pipe_hazard_ctrl #(
   parameter int NSTAGE    = 3,
   parameter int REG_W     = 5,
   parameter int FWD_EN    = 1,
   parameter int JMP_STAGE = 1,
   parameter int CNT_W     = 16,
   parameter int SEL_W     = $clog2(NSTAGE + 1)
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   logic [NSTAGE-1:0] vld_q, vld_d, we_q, we_d, ld_q, ld_d;
   logic [REG_W-1:0]  rd_q [NSTAGE];
   logic [REG_W-1:0]  rd_d [NSTAGE];
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic [1:0]        src_use;
   logic [REG_W-1:0]  src_ind [2];
   logic [1:0]        src_hit, src_ld;
   logic [SEL_W-1:0]  src_idx [2];
   logic [SEL_W-1:0]  src_sel [2];
   logic              hazard, stall, issue;
   logic [NSTAGE-1:0] flush_vec;
   logic [SEL_W-1:0]  inflight;

   assign src_use    = {hz.dec_rs2_use, hz.dec_rs1_use};
   assign src_ind[0] = hz.dec_rs1_ind;
   assign src_ind[1] = hz.dec_rs2_ind;

   // Scan from the oldest entry down so the youngest (lowest index) match is the one kept.
   always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < 2; s++) begin
         src_hit[s] = 1'b0;
         src_idx[s] = '0;
         src_ld[s]  = 1'b0;
         src_sel[s] = '0;
         for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (src_use[s] && (src_ind[s] != '0) && vld_q[i] && we_q[i] &&
                (rd_q[i] == src_ind[s])) begin
               src_hit[s] = 1'b1;
               src_idx[s] = SEL_W'(i);
               src_ld[s]  = ld_q[i];
            end
         end
         if (FWD_EN != 0) begin
            if (src_hit[s]) src_sel[s] = src_idx[s] + 1'b1;
            // Load data only exists from entry 1 onward.
            if (src_hit[s] && (src_idx[s] == '0) && src_ld[s]) hazard = 1'b1;
         end else if (src_hit[s]) begin
            hazard = 1'b1;
         end
      end
   end

   always_comb begin
      stall     = hz.dec_valid & ~hz.jmp_take & hazard;
      issue     = hz.dec_valid & ~stall & ~hz.jmp_take;
      flush_vec = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         flush_vec[i] = hz.jmp_take && (i < JMP_STAGE);
      end
   end

   always_comb begin
      vld_d    = '0;
      we_d     = '0;
      ld_d     = '0;
      vld_d[0] = issue;
      we_d[0]  = hz.dec_rd_we;
      ld_d[0]  = hz.dec_is_load;
      rd_d[0]  = hz.dec_rd_ind;
      for (int i = 1; i < NSTAGE; i++) begin
         vld_d[i] = vld_q[i-1] & ~flush_vec[i-1];
         we_d[i]  = we_q[i-1];
         ld_d[i]  = ld_q[i-1];
         rd_d[i]  = rd_q[i-1];
      end
      inflight = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         inflight = inflight + SEL_W'(vld_q[i]);
      end
      stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (hz.jmp_take && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         we_q        <= '0;
         ld_q        <= '0;
         for (int i = 0; i < NSTAGE; i++) rd_q[i] <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         vld_q       <= vld_d;
         we_q        <= we_d;
         ld_q        <= ld_d;
         for (int i = 0; i < NSTAGE; i++) rd_q[i] <= rd_d[i];
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall        = stall;
   assign hz.issue        = issue;
   assign hz.fwd_rs1_sel  = src_sel[0];
   assign hz.fwd_rs2_sel  = src_sel[1];
   assign hz.flush_d      = hz.jmp_take;
   assign hz.flush_vec    = flush_vec;
   assign hz.inflight_cnt = inflight;
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share one decode stream and are compared
// against a queue-of-instructions reference model, plus directed checks from the test plan.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       d_valid, d_rs1_use, d_rs2_use, d_we, d_ld, d_jmp;
   logic [4:0] d_rs1, d_rs2, d_rd;

   pipe_hazard_ctrl_if #(.NSTAGE(3), .REG_W(5), .CNT_W(16)) i0 ();
   pipe_hazard_ctrl_if #(.NSTAGE(3), .REG_W(5), .CNT_W(16)) i1 ();
   pipe_hazard_ctrl_if #(.NSTAGE(4), .REG_W(5), .CNT_W(4))  i2 ();

   assign i0.dec_valid = d_valid;   assign i1.dec_valid = d_valid;   assign i2.dec_valid = d_valid;
   assign i0.dec_rs1_ind = d_rs1;   assign i1.dec_rs1_ind = d_rs1;   assign i2.dec_rs1_ind = d_rs1;
   assign i0.dec_rs1_use = d_rs1_use; assign i1.dec_rs1_use = d_rs1_use; assign i2.dec_rs1_use = d_rs1_use;
   assign i0.dec_rs2_ind = d_rs2;   assign i1.dec_rs2_ind = d_rs2;   assign i2.dec_rs2_ind = d_rs2;
   assign i0.dec_rs2_use = d_rs2_use; assign i1.dec_rs2_use = d_rs2_use; assign i2.dec_rs2_use = d_rs2_use;
   assign i0.dec_rd_ind = d_rd;     assign i1.dec_rd_ind = d_rd;     assign i2.dec_rd_ind = d_rd;
   assign i0.dec_rd_we = d_we;      assign i1.dec_rd_we = d_we;      assign i2.dec_rd_we = d_we;
   assign i0.dec_is_load = d_ld;    assign i1.dec_is_load = d_ld;    assign i2.dec_is_load = d_ld;
   assign i0.jmp_take = d_jmp;      assign i1.jmp_take = d_jmp;      assign i2.jmp_take = d_jmp;

   pipe_hazard_ctrl #(.NSTAGE(3), .REG_W(5), .FWD_EN(1), .JMP_STAGE(1), .CNT_W(16))
      u0 (.clk(clk), .rst_n(rst_n), .hz(i0.slave));
   pipe_hazard_ctrl #(.NSTAGE(3), .REG_W(5), .FWD_EN(0), .JMP_STAGE(1), .CNT_W(16))
      u1 (.clk(clk), .rst_n(rst_n), .hz(i1.slave));
   pipe_hazard_ctrl #(.NSTAGE(4), .REG_W(5), .FWD_EN(1), .JMP_STAGE(3), .CNT_W(4))
      u2 (.clk(clk), .rst_n(rst_n), .hz(i2.slave));

   int NS[3] = '{3, 3, 4};
   int FE[3] = '{1, 0, 1};
   int JS[3] = '{1, 1, 3};
   int CW[3] = '{16, 16, 4};

   // Reference model: every live instruction of every configuration, with its current stage.
   typedef struct {
      int inst;
      int pos;
      int rd;
      bit we;
      bit ld;
   } rec_t;
   rec_t mq[$];
   int   m_sc[3];
   int   m_fc[3];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void lookup(input int k, input bit use_s, input int ind,
                                  output int best, output bit bld);
      best = -1;
      bld  = 1'b0;
      if (use_s && ind != 0) begin
         foreach (mq[j]) begin
            if (mq[j].inst == k && mq[j].we && mq[j].rd == ind && (best < 0 || mq[j].pos < best)) begin
               best = mq[j].pos;
               bld  = mq[j].ld;
            end
         end
      end
   endfunction

   function automatic void model_out(input int k, output bit st, output bit iss, output int s1,
                                     output int s2, output int fv, output int inf);
      int b1, b2;
      bit l1, l2, haz;
      lookup(k, d_rs1_use, int'(d_rs1), b1, l1);
      lookup(k, d_rs2_use, int'(d_rs2), b2, l2);
      if (FE[k] != 0) begin
         s1  = b1 + 1;
         s2  = b2 + 1;
         haz = (b1 == 0 && l1) || (b2 == 0 && l2);
      end else begin
         s1  = 0;
         s2  = 0;
         haz = (b1 >= 0) || (b2 >= 0);
      end
      st  = d_valid && !d_jmp && haz;
      iss = d_valid && !st && !d_jmp;
      fv  = d_jmp ? (1 << JS[k]) - 1 : 0;
      inf = 0;
      foreach (mq[j]) if (mq[j].inst == k) inf++;
   endfunction

   task automatic cmp(input int k, input logic [31:0] st, input logic [31:0] iss,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] fd,
                      input logic [31:0] fv, input logic [31:0] inf, input logic [31:0] sc,
                      input logic [31:0] fc);
      bit e_st, e_iss;
      int e_s1, e_s2, e_fv, e_inf;
      model_out(k, e_st, e_iss, e_s1, e_s2, e_fv, e_inf);
      chk($sformatf("u%0d.stall", k), st, 32'(e_st));
      chk($sformatf("u%0d.issue", k), iss, 32'(e_iss));
      chk($sformatf("u%0d.fwd_rs1_sel", k), s1, e_s1);
      chk($sformatf("u%0d.fwd_rs2_sel", k), s2, e_s2);
      chk($sformatf("u%0d.flush_d", k), fd, 32'(d_jmp));
      chk($sformatf("u%0d.flush_vec", k), fv, e_fv);
      chk($sformatf("u%0d.inflight_cnt", k), inf, e_inf);
      chk($sformatf("u%0d.stall_cnt", k), sc, m_sc[k]);
      chk($sformatf("u%0d.flush_cnt", k), fc, m_fc[k]);
   endtask

   task automatic check_all();
      cmp(0, 32'(i0.stall), 32'(i0.issue), 32'(i0.fwd_rs1_sel), 32'(i0.fwd_rs2_sel),
          32'(i0.flush_d), 32'(i0.flush_vec), 32'(i0.inflight_cnt), 32'(i0.stall_cnt), 32'(i0.flush_cnt));
      cmp(1, 32'(i1.stall), 32'(i1.issue), 32'(i1.fwd_rs1_sel), 32'(i1.fwd_rs2_sel),
          32'(i1.flush_d), 32'(i1.flush_vec), 32'(i1.inflight_cnt), 32'(i1.stall_cnt), 32'(i1.flush_cnt));
      cmp(2, 32'(i2.stall), 32'(i2.issue), 32'(i2.fwd_rs1_sel), 32'(i2.fwd_rs2_sel),
          32'(i2.flush_d), 32'(i2.flush_vec), 32'(i2.inflight_cnt), 32'(i2.stall_cnt), 32'(i2.flush_cnt));
   endtask

   task automatic model_advance();
      bit   st[3], iss[3];
      int   s1, s2, fv, inf;
      rec_t nq[$];
      rec_t r;
      for (int k = 0; k < 3; k++) begin
         model_out(k, st[k], iss[k], s1, s2, fv, inf);
         if (st[k] && m_sc[k] < (1 << CW[k]) - 1) m_sc[k]++;
         if (d_jmp && m_fc[k] < (1 << CW[k]) - 1) m_fc[k]++;
      end
      foreach (mq[j]) begin
         r = mq[j];
         if (!(d_jmp && r.pos < JS[r.inst])) begin
            r.pos++;
            if (r.pos < NS[r.inst]) nq.push_back(r);
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (iss[k]) begin
            r.inst = k; r.pos = 0; r.rd = int'(d_rd); r.we = d_we; r.ld = d_ld;
            nq.push_back(r);
         end
      end
      mq = nq;
   endtask

   task automatic fin();
      check_all();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      @(negedge clk);
      fin();
   endtask

   task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit ld, input bit jmp);
      d_valid = v; d_rs1 = 5'(rs1); d_rs1_use = u1; d_rs2 = 5'(rs2); d_rs2_use = u2;
      d_rd = 5'(rd); d_we = we; d_ld = ld; d_jmp = jmp;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      m_sc = '{0, 0, 0};
      m_fc = '{0, 0, 0};
      @(negedge clk);
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // Fill the shadow with valid writes, then reset with a would-be hazard on decode.
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0); cyc();
      set_in(1, 0, 0, 0, 0, 6, 1, 1, 0); cyc();
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0); cyc();
      set_in(1, 5, 1, 6, 1, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_inflight", 32'(i0.inflight_cnt), 32'd0);
      chk("rst_async_stall", 32'(i0.stall), 32'd0);
      do_reset();

      // Back-to-back ALU forwarding.
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
      @(negedge clk);
      chk("rel_inflight", 32'(i0.inflight_cnt), 32'd0);
      chk("rel_stall", 32'(i0.stall), 32'd0);
      chk("rel_stall_cnt", 32'(i0.stall_cnt), 32'd0);
      chk("rel_flush_cnt", 32'(i0.flush_cnt), 32'd0);
      fin();
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("alu_fwd1", 32'(i0.fwd_rs1_sel), 32'd1);
      chk("alu_nostall", 32'(i0.stall), 32'd0);
      fin();
      @(negedge clk);
      chk("alu_fwd2", 32'(i0.fwd_rs1_sel), 32'd2);
      fin();

      // Load-use.
      do_reset();
      set_in(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
      set_in(1, 0, 0, 7, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("lu_stall", 32'(i0.stall), 32'd1);
      chk("lu_issue", 32'(i0.issue), 32'd0);
      fin();
      chk("lu_stall_cnt", 32'(i0.stall_cnt), 32'd1);
      @(negedge clk);
      chk("lu_release", 32'(i0.stall), 32'd0);
      chk("lu_fwd2", 32'(i0.fwd_rs2_sel), 32'd2);
      fin();

      // x0 never matches; youngest writer wins.
      do_reset();
      set_in(1, 0, 0, 0, 0, 0, 1, 0, 0); cyc();
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("x0_sel", 32'(i0.fwd_rs1_sel), 32'd0);
      chk("x0_stall", 32'(i1.stall), 32'd0);
      fin();
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc();
      cyc();
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("young_sel", 32'(i0.fwd_rs1_sel), 32'd1);
      fin();

      // Jump overrides a load-use hazard.
      do_reset();
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc();
      set_in(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
      set_in(1, 0, 0, 7, 1, 0, 0, 0, 1);
      @(negedge clk);
      chk("jmp_stall", 32'(i0.stall), 32'd0);
      chk("jmp_issue", 32'(i0.issue), 32'd0);
      chk("jmp_flush_d", 32'(i0.flush_d), 32'd1);
      chk("jmp_flush_vec", 32'(i0.flush_vec), 32'd1);
      fin();
      chk("jmp_flush_cnt", 32'(i0.flush_cnt), 32'd1);
      set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("jmp_after_inflight", 32'(i0.inflight_cnt), 32'd1);
      chk("jmp_after_sel", 32'(i0.fwd_rs1_sel), 32'd3);
      fin();

      // No bypass network: stall until the writer retires.
      do_reset();
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0); cyc();
      set_in(1, 9, 1, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk($sformatf("nofwd_stall%0d", n), 32'(i1.stall), 32'd1);
         fin();
      end
      @(negedge clk);
      chk("nofwd_release", 32'(i1.stall), 32'd0);
      chk("nofwd_issue", 32'(i1.issue), 32'd1);
      chk("nofwd_sel", 32'(i1.fwd_rs1_sel), 32'd0);
      chk("nofwd_stall_cnt", 32'(i1.stall_cnt), 32'd3);
      fin();

      // 20 load-use stalls saturate the 4-bit counter.
      do_reset();
      for (int n = 0; n < 20; n++) begin
         set_in(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
         set_in(1, 0, 0, 7, 1, 0, 0, 0, 0); cyc();
      end
      chk("sat_stall_cnt", 32'(i2.stall_cnt), 32'd15);
      chk("wide_stall_cnt", 32'(i0.stall_cnt), 32'd20);

      // Random traffic over a small register set to provoke hazards.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
